e203_expl_axi_sram: RTL and testbench

E203_EXPL_AXI_SRAM -- requirements
Module: e203_expl_axi_sram

---
 rtl/e203_axi_pkg.sv | 28 ++
 rtl/e203_sram_1rw.sv | 52 +++++
 rtl/e203_expl_axi_sram.sv | 229 ++++++++++++++++++++++
 tb/tb_e203_expl_axi_sram.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/e203_axi_pkg.sv
// e203_axi_pkg
// Shared definitions for the expl_axi SRAM slave: the controller state
// encoding, AXI burst/response codes and the burst legality check.
package e203_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_DATA = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4
    } axi_state_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] SIZE_WORD   = 3'b010;

    // Only FIXED/INCR bursts of full 32-bit beats touch the memory.
    function automatic logic burst_is_err(input logic [1:0] burst, input logic [2:0] size);
        return (burst == BURST_WRAP) || (burst == 2'b11) || (size != SIZE_WORD);
    endfunction

endpackage

// File: rtl/e203_sram_1rw.sv
// e203_sram_1rw
// Single-port 32-bit SRAM with per-byte write enables and a registered
// read port (data appears the cycle after a read request).
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (read register only)
//   en_i       : access enable
//   we_i       : 1 = write (bytes selected by be_i), 0 = read
//   be_i       : byte enables for writes
//   addr_i     : word address
//   wdata_i    : write data
//   rdata_o    : registered read data; holds its value when no read is issued
module e203_sram_1rw #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    // Storage is deliberately not reset: contents survive rst.
    logic [31:0] mem_q [0:(1<<AW)-1];
    logic [31:0] rdata_q;

    // Byte-masked write port.
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Read data register; it only changes on a read, so the read beat
    // presented upstream stays stable while the master stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= 32'd0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/e203_expl_axi_sram.sv
// e203_expl_axi_sram
// AXI slave backed by a single-port SRAM, serving the E203 expl_axi port.
// One transaction at a time; simultaneous AW/AR requests are granted
// round-robin (write first after reset).
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   ar*/aw*               : address channels (cache/prot/lock ignored)
//   w*                    : write data channel
//   r*                    : read data channel
//   b*                    : write response channel
module e203_expl_axi_sram
    import e203_axi_pkg::*;
#(
    parameter int MEM_AW = 10,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // AR channel
    input  logic              arvalid,
    output logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [1:0]        arburst,
    input  logic [3:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [3:0]        arcache,
    input  logic [2:0]        arprot,
    input  logic [1:0]        arlock,
    // AW channel
    input  logic              awvalid,
    output logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [1:0]        awburst,
    input  logic [3:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [3:0]        awcache,
    input  logic [2:0]        awprot,
    input  logic [1:0]        awlock,
    // W channel
    input  logic              wvalid,
    output logic              wready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    // R channel
    output logic              rvalid,
    input  logic              rready,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    // B channel
    output logic              bvalid,
    input  logic              bready,
    output logic [1:0]        bresp
);

    axi_state_e        state_q, state_d;
    logic [MEM_AW-1:0] idx_q, idx_d;
    logic [3:0]        len_q, len_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        burst_q, burst_d;
    logic [2:0]        size_q, size_d;
    logic              wr_err_q, wr_err_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              rr_wr_q, rr_wr_d;   // 1: write wins the next tie

    logic              grant_wr_s, grant_rd_s;
    logic              beat_err_s, last_beat_s, wlast_bad_s;
    logic [MEM_AW-1:0] idx_next_s;
    logic              sram_en_s, sram_we_s;
    logic [3:0]        sram_be_s;
    logic [31:0]       sram_rdata_s;
    logic              unused_s;

    assign unused_s = ^{arcache, arprot, arlock, awcache, awprot, awlock,
                        araddr[ADDR_W-1:MEM_AW+2], araddr[1:0],
                        awaddr[ADDR_W-1:MEM_AW+2], awaddr[1:0]};

    assign grant_wr_s  = awvalid && (!arvalid || rr_wr_q);
    assign grant_rd_s  = arvalid && (!awvalid || !rr_wr_q);
    assign beat_err_s  = burst_is_err(burst_q, size_q);
    assign last_beat_s = (cnt_q == len_q);
    assign wlast_bad_s = (wlast != last_beat_s);
    // FIXED keeps the index; INCR wraps naturally in MEM_AW bits.
    assign idx_next_s  = (burst_q == BURST_FIXED) ? idx_q : (idx_q + MEM_AW'(1));

    // State and transaction context registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            len_q    <= 4'd0;
            cnt_q    <= 4'd0;
            burst_q  <= 2'b00;
            size_q   <= 3'b000;
            wr_err_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rr_wr_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            burst_q  <= burst_d;
            size_q   <= size_d;
            wr_err_q <= wr_err_d;
            bresp_q  <= bresp_d;
            rr_wr_q  <= rr_wr_d;
        end
    end

    // Next-state, arbitration and SRAM request decode.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        burst_d   = burst_q;
        size_d    = size_q;
        wr_err_d  = wr_err_q;
        bresp_d   = bresp_q;
        rr_wr_d   = rr_wr_q;
        awready   = 1'b0;
        arready   = 1'b0;
        sram_en_s = 1'b0;
        sram_we_s = 1'b0;
        sram_be_s = 4'b0000;

        case (state_q)
            ST_IDLE: begin
                awready = grant_wr_s;
                arready = grant_rd_s;
                if (grant_wr_s) begin
                    idx_d    = awaddr[MEM_AW+1:2];
                    len_d    = awlen;
                    burst_d  = awburst;
                    size_d   = awsize;
                    cnt_d    = 4'd0;
                    wr_err_d = 1'b0;
                    rr_wr_d  = 1'b0;
                    state_d  = ST_WR_DATA;
                end else if (grant_rd_s) begin
                    idx_d    = araddr[MEM_AW+1:2];
                    len_d    = arlen;
                    burst_d  = arburst;
                    size_d   = arsize;
                    cnt_d    = 4'd0;
                    rr_wr_d  = 1'b1;
                    state_d  = ST_RD_ADDR;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_WR_DATA: begin
                if (wvalid) begin
                    sram_en_s = !beat_err_s;
                    sram_we_s = 1'b1;
                    sram_be_s = wstrb;
                    if (wlast_bad_s) begin
                        wr_err_d = 1'b1;
                    end else begin
                        wr_err_d = wr_err_q;
                    end
                    // Burst length, not wlast, decides where the burst ends.
                    if (last_beat_s) begin
                        bresp_d = (beat_err_s || wr_err_q || wlast_bad_s) ? RESP_SLVERR : RESP_OKAY;
                        state_d = ST_WR_RESP;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        idx_d   = idx_next_s;
                    end
                end else begin
                    state_d = ST_WR_DATA;
                end
            end
            ST_WR_RESP: begin
                if (bready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_RD_ADDR: begin
                sram_en_s = !beat_err_s;
                idx_d     = idx_next_s;
                state_d   = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (rready) begin
                    if (last_beat_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        // Prefetch the next word so data streams at one beat per cycle.
                        sram_en_s = !beat_err_s;
                        cnt_d     = cnt_q + 4'd1;
                        idx_d     = idx_next_s;
                    end
                end else begin
                    state_d = ST_RD_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    e203_sram_1rw #(
        .AW (MEM_AW)
    ) u_sram (
        .clk     (clk),
        .rst     (rst),
        .en_i    (sram_en_s),
        .we_i    (sram_we_s),
        .be_i    (sram_be_s),
        .addr_i  (idx_q),
        .wdata_i (wdata),
        .rdata_o (sram_rdata_s)
    );

    assign wready = (state_q == ST_WR_DATA);
    assign bvalid = (state_q == ST_WR_RESP);
    assign bresp  = bresp_q;
    assign rvalid = (state_q == ST_RD_DATA);
    assign rlast  = (state_q == ST_RD_DATA) && last_beat_s;
    assign rresp  = ((state_q == ST_RD_DATA) && beat_err_s) ? RESP_SLVERR : RESP_OKAY;
    assign rdata  = sram_rdata_s;

endmodule

// File: tb/tb_e203_expl_axi_sram.sv
// tb_e203_expl_axi_sram
// Self-checking bench: directed scenarios plus randomized bursts, all
// checked against a word-array memory model with per-byte valid flags.
module tb_e203_expl_axi_sram;

    localparam int MEM_AW = 10;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 1 << MEM_AW;

    logic              clk;
    logic              rst;
    logic              arvalid, arready;
    logic [ADDR_W-1:0] araddr;
    logic [1:0]        arburst;
    logic [3:0]        arlen;
    logic [2:0]        arsize;
    logic              awvalid, awready;
    logic [ADDR_W-1:0] awaddr;
    logic [1:0]        awburst;
    logic [3:0]        awlen;
    logic [2:0]        awsize;
    logic              wvalid, wready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              rvalid, rready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              bvalid, bready;
    logic [1:0]        bresp;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [31:0] mdl   [DEPTH];
    logic [3:0]  known [DEPTH];

    e203_expl_axi_sram #(.MEM_AW(MEM_AW), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arburst(arburst),
        .arlen(arlen), .arsize(arsize), .arcache(4'h0), .arprot(3'h0), .arlock(2'h0),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awburst(awburst),
        .awlen(awlen), .awsize(awsize), .awcache(4'h0), .awprot(3'h0), .awlock(2'h0),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_err(input logic [1:0] burst, input logic [2:0] size);
        return (burst == 2'b10) || (burst == 2'b11) || (size != 3'b010);
    endfunction

    // Word touched by beat n: address modulo depth, FIXED stays put.
    function automatic int word_of(input logic [31:0] addr, input logic [1:0] burst, input int n);
        int base;
        base = int'((addr >> 2) % DEPTH);
        if (burst == 2'b00) return base;
        return (base + n) % DEPTH;
    endfunction

    task automatic aw_hs(input logic [31:0] addr, input int len, input logic [1:0] burst, input logic [2:0] size);
        bit hs = 1'b0;
        awvalid = 1'b1; awaddr = addr; awlen = 4'(len); awburst = burst; awsize = size;
        for (int t = 0; t < 100 && !hs; t++) begin
            #2;
            hs = awready;
            @(posedge clk);
            #1;
        end
        awvalid = 1'b0;
        if (!hs) check("aw_timeout", 32'd0, 32'd1);
    endtask

    task automatic ar_hs(input logic [31:0] addr, input int len, input logic [1:0] burst, input logic [2:0] size);
        bit hs = 1'b0;
        arvalid = 1'b1; araddr = addr; arlen = 4'(len); arburst = burst; arsize = size;
        for (int t = 0; t < 100 && !hs; t++) begin
            #2;
            hs = arready;
            @(posedge clk);
            #1;
        end
        arvalid = 1'b0;
        if (!hs) check("ar_timeout", 32'd0, 32'd1);
    endtask

    // W beats; seq=1 sends 1,2,3..., else random data. wlast is raised on beat last_at.
    task automatic w_beats(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [3:0] strb, input int last_at,
                           input bit seq, output bit mism);
        mism = 1'b0;
        for (int i = 0; i <= len; i++) begin
            bit hs = 1'b0;
            wvalid = 1'b1;
            wdata  = seq ? 32'(i + 1) : $urandom;
            wstrb  = strb;
            wlast  = (i == last_at);
            for (int t = 0; t < 100 && !hs; t++) begin
                #2;
                hs = wready;
                @(posedge clk);
                #1;
            end
            if (!hs) check("w_timeout", 32'd0, 32'd1);
            if (wlast != (i == len)) mism = 1'b1;
            if (!is_err(burst, size)) begin
                int w;
                w = word_of(addr, burst, i);
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) begin
                        mdl[w][8*b +: 8] = wdata[8*b +: 8];
                        known[w][b] = 1'b1;
                    end
                end
            end
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic b_wait(input logic [1:0] exp_resp);
        bit seen = 1'b0;
        logic [1:0] r = 2'b00;
        bready = 1'b1;
        for (int t = 0; t < 100 && !seen; t++) begin
            #2;
            seen = bvalid;
            r = bresp;
            @(posedge clk);
            #1;
        end
        bready = 1'b0;
        check("b_seen", 32'(seen), 32'd1);
        check("bresp", 32'(r), 32'(exp_resp));
    endtask

    task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                            input logic [2:0] size, input logic [3:0] strb, input int last_at,
                            input bit seq);
        bit mism;
        aw_hs(addr, len, burst, size);
        w_beats(addr, len, burst, size, strb, last_at, seq, mism);
        b_wait((is_err(burst, size) || mism) ? 2'b10 : 2'b00);
    endtask

    // R beats after an AR handshake. mode: 0 rready high, 1 toggling, 2 random.
    task automatic r_beats(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input logic [2:0] size, input int mode, input bit chk_lat);
        int beat = 0;
        int cyc  = 1;
        bit first = 1'b1;
        bit stalled = 1'b0;
        logic [31:0] sv_data = 32'd0;
        logic [1:0]  sv_resp = 2'b00;
        logic        sv_last = 1'b0;
        while (beat <= len && cyc < 400) begin
            case (mode)
                0:       rready = 1'b1;
                1:       rready = cyc[0];
                default: rready = 1'($urandom_range(0, 1));
            endcase
            #2;
            if (stalled) begin
                check("r_stall_valid", 32'(rvalid), 32'd1);
                check("r_stall_data", rdata, sv_data);
                check("r_stall_resp", 32'(rresp), 32'(sv_resp));
                check("r_stall_last", 32'(rlast), 32'(sv_last));
            end
            if (rvalid) begin
                if (first && chk_lat) check("r_first_latency", 32'(cyc), 32'd2);
                first = 1'b0;
                if (rready) begin
                    logic [31:0] m;
                    int w;
                    w = word_of(addr, burst, beat);
                    m = {{8{known[w][3]}}, {8{known[w][2]}}, {8{known[w][1]}}, {8{known[w][0]}}};
                    check("r_last", 32'(rlast), 32'(beat == len));
                    check("r_resp", 32'(rresp), is_err(burst, size) ? 32'd2 : 32'd0);
                    if (!is_err(burst, size)) check("r_data", rdata & m, mdl[w] & m);
                    beat++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    sv_data = rdata;
                    sv_resp = rresp;
                    sv_last = rlast;
                end
            end else begin
                stalled = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        rready = 1'b0;
        check("r_beat_count", 32'(beat), 32'(len + 1));
        #2;
        check("r_done_idle", 32'(rvalid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input logic [2:0] size, input int mode, input bit chk_lat);
        ar_hs(addr, len, burst, size);
        r_beats(addr, len, burst, size, mode, chk_lat);
    endtask

    initial begin
        bit mism;
        for (int i = 0; i < DEPTH; i++) begin
            mdl[i]   = 32'd0;
            known[i] = 4'b0000;
        end
        rst = 1'b1;
        arvalid = 1'b0; araddr = 32'd0; arburst = 2'b01; arlen = 4'd0; arsize = 3'b010;
        awvalid = 1'b0; awaddr = 32'd0; awburst = 2'b01; awlen = 4'd0; awsize = 3'b010;
        wvalid = 1'b0; wdata = 32'd0; wstrb = 4'h0; wlast = 1'b0;
        rready = 1'b0; bready = 1'b0;
        tick();
        tick();
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready",  32'(wready),  32'd0);
        check("rst_rvalid",  32'(rvalid),  32'd0);
        check("rst_rlast",   32'(rlast),   32'd0);
        check("rst_bvalid",  32'(bvalid),  32'd0);
        check("rst_rresp",   32'(rresp),   32'd0);
        check("rst_bresp",   32'(bresp),   32'd0);
        check("rst_rdata",   rdata,        32'd0);
        rst = 1'b0;
        tick();

        // Simultaneous requests right after reset: write wins, then read wins.
        awvalid = 1'b1; awaddr = 32'h0000_0010; awlen = 4'd3; awburst = 2'b01; awsize = 3'b010;
        arvalid = 1'b1; araddr = 32'h0000_0010; arlen = 4'd3; arburst = 2'b01; arsize = 3'b010;
        #2;
        check("arb1_awready", 32'(awready), 32'd1);
        check("arb1_arready", 32'(arready), 32'd0);
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        arvalid = 1'b0;
        w_beats(32'h0000_0010, 3, 2'b01, 3'b010, 4'hF, 3, 1'b1, mism);
        b_wait(2'b00);
        awvalid = 1'b1; awaddr = 32'h0000_0040; awlen = 4'd0;
        arvalid = 1'b1;
        #2;
        check("arb2_arready", 32'(arready), 32'd1);
        check("arb2_awready", 32'(awready), 32'd0);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        awvalid = 1'b0;
        r_beats(32'h0000_0010, 3, 2'b01, 3'b010, 0, 1'b1);

        // Same read again, then a fresh independent read with latency check.
        do_read(32'h0000_0010, 3, 2'b01, 3'b010, 0, 1'b1);

        // 16-beat read with rready toggling.
        do_write(32'h0000_0100, 15, 2'b01, 3'b010, 4'hF, 15, 1'b0);
        do_read(32'h0000_0100, 15, 2'b01, 3'b010, 1, 1'b1);

        // Error bursts: WRAP write leaves memory alone; early wlast flags SLVERR.
        do_write(32'h0000_0010, 1, 2'b10, 3'b010, 4'hF, 1, 1'b0);
        do_read(32'h0000_0010, 1, 2'b01, 3'b010, 0, 1'b0);
        do_write(32'h0000_0040, 3, 2'b01, 3'b010, 4'hF, 1, 1'b0);
        do_read(32'h0000_0040, 3, 2'b01, 3'b010, 2, 1'b0);
        do_read(32'h0000_0010, 0, 2'b01, 3'b011, 0, 1'b0);
        do_write(32'h0000_0010, 0, 2'b01, 3'b001, 4'hF, 0, 1'b0);
        do_read(32'h0000_0010, 3, 2'b01, 3'b010, 0, 1'b0);

        // Wrap at top of memory (upper address bits alias) and byte strobes.
        do_write(32'h0000_0000, 0, 2'b01, 3'b010, 4'hF, 0, 1'b0);
        do_write(32'h8000_0FFC, 1, 2'b01, 3'b010, 4'hF, 1, 1'b0);
        do_read(32'h0000_0FFC, 1, 2'b01, 3'b010, 0, 1'b0);
        do_read(32'h0000_0000, 0, 2'b01, 3'b010, 0, 1'b0);
        do_write(32'h0000_0020, 0, 2'b01, 3'b010, 4'hF, 0, 1'b0);
        do_write(32'h0000_0020, 0, 2'b01, 3'b010, 4'b0101, 0, 1'b0);
        do_read(32'h0000_0020, 0, 2'b01, 3'b010, 0, 1'b0);
        do_write(32'h0000_0030, 2, 2'b00, 3'b010, 4'hF, 2, 1'b0);
        do_read(32'h0000_0030, 2, 2'b00, 3'b010, 2, 1'b0);

        // Reset during the second beat of a 4-beat read.
        ar_hs(32'h0000_0010, 3, 2'b01, 3'b010);
        tick();
        rready = 1'b1;
        #2;
        check("rstmid_beat1_valid", 32'(rvalid), 32'd1);
        @(posedge clk);
        #1;
        rready = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("rstmid_rvalid", 32'(rvalid), 32'd0);
        tick();
        check("rstmid_rvalid_next", 32'(rvalid), 32'd0);
        check("rstmid_rlast", 32'(rlast), 32'd0);
        rst = 1'b0;
        tick();
        check("rstmid_idle_rvalid", 32'(rvalid), 32'd0);
        do_read(32'h0000_0010, 3, 2'b01, 3'b010, 0, 1'b1);

        // Randomized write/read pairs.
        for (int n = 0; n < 24; n++) begin
            logic [31:0] a;
            logic [1:0]  bu;
            int          ln;
            logic [3:0]  sb;
            a  = $urandom & 32'hFFFF_FFFC;
            bu = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b01;
            ln = $urandom_range(0, 15);
            sb = 4'($urandom_range(1, 15));
            do_write(a, ln, bu, 3'b010, sb, ln, 1'b0);
            do_read(a, ln, bu, 3'b010, $urandom_range(0, 2), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
